// File: rtl/branch_redirect_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_redirect_unit_pkg : shared types and constants for the redirect unit
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package branch_redirect_unit_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

  localparam logic [63:0] BRU_PC_INCR    = 64'd4;
  localparam logic [63:0] BRU_RESET_PC   = 64'h0;
  localparam logic [63:0] BRU_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

`default_nettype wire

// File: rtl/branch_stat_counter.sv
// ---------------------------------------------------------------------------
// branch_stat_counter : saturating event counter with synchronous reset
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module branch_stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stick at all-ones so long-running debug statistics never alias to small values.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

`default_nettype wire

// File: rtl/branch_redirect_unit.sv
// ---------------------------------------------------------------------------
// branch_redirect_unit : fetch PC owner, predict-not-taken redirect and flush
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = BRU_RESET_PC,
  parameter int          CNT_W    = 32,
  parameter logic [63:0] PC_INCR  = BRU_PC_INCR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             BranchValid,
  input  logic             BranchSel,
  input  logic [63:0]      BranchTarget,
  output logic [63:0]      PC_Out,
  output logic             FlushIFID,
  output logic             FlushIDEX,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount
);

  bru_state_e  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic        inc_branch;
  logic        inc_taken;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (BranchValid && BranchSel) begin
          pc_d       = BranchTarget & BRU_ALIGN_MASK;
          flush_d    = 1'b1;
          misalign_d = (BranchTarget[1:0] != 2'b00);
          state_d    = ST_FLUSH;
        end else if (!Stall) begin
          pc_d = pc_q + PC_INCR;
        end
      end
      // Inputs here belong to instructions being killed, so they are ignored.
      ST_FLUSH: begin
        pc_d    = pc_q + PC_INCR;
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign inc_branch = (state_q == ST_RUN) && BranchValid;
  assign inc_taken  = inc_branch && BranchSel;

  branch_stat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_branch),
    .count (BranchCount)
  );

  branch_stat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_taken),
    .count (TakenCount)
  );

  assign PC_Out      = pc_q;
  assign FlushIFID   = flush_q;
  assign FlushIDEX   = flush_q;
  assign MisalignErr = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_unit : vector table plus directed sequences, queue scoreboard
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        BranchValid;
  logic        BranchSel;
  logic [63:0] BranchTarget;

  logic [63:0] pc_a, pc_b;
  logic        fifd_a, fidex_a, mis_a, fifd_b, fidex_b, mis_b;
  logic [31:0] bc_a, tc_a;
  logic [3:0]  bc_b, tc_b;

  always #5 clk = ~clk;

  branch_redirect_unit #(.RESET_PC(64'h0), .CNT_W(32), .PC_INCR(64'd4)) dut_a (
    .clk(clk), .reset(reset), .Stall(Stall), .BranchValid(BranchValid),
    .BranchSel(BranchSel), .BranchTarget(BranchTarget), .PC_Out(pc_a),
    .FlushIFID(fifd_a), .FlushIDEX(fidex_a), .MisalignErr(mis_a),
    .BranchCount(bc_a), .TakenCount(tc_a)
  );

  branch_redirect_unit #(.RESET_PC(64'h0), .CNT_W(4), .PC_INCR(64'd4)) dut_b (
    .clk(clk), .reset(reset), .Stall(Stall), .BranchValid(BranchValid),
    .BranchSel(BranchSel), .BranchTarget(BranchTarget), .PC_Out(pc_b),
    .FlushIFID(fifd_b), .FlushIDEX(fidex_b), .MisalignErr(mis_b),
    .BranchCount(bc_b), .TakenCount(tc_b)
  );

  typedef struct {
    logic [63:0] pc;
    logic        fl;
    logic        mis;
    logic [31:0] bc;
    logic [31:0] tc;
    logic [3:0]  bc4;
    logic [3:0]  tc4;
  } exp_t;

  typedef struct {
    logic        st;
    logic        bv;
    logic        bs;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic        fl;
    logic        mis;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[22];
  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] m_bc, m_tc;
  logic [3:0]  m_bc4, m_tc4;
  logic        m_flush;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, push its expectation, then pop and check after the edge.
  task automatic step(input logic rst_i, input logic st, input logic bv, input logic bs,
                      input logic [63:0] tgt, input logic [63:0] e_pc,
                      input logic e_fl, input logic e_mis);
    exp_t e;
    reset = rst_i; Stall = st; BranchValid = bv; BranchSel = bs; BranchTarget = tgt;
    if (rst_i) begin
      m_bc = '0; m_tc = '0; m_bc4 = '0; m_tc4 = '0;
    end else if (!m_flush && bv) begin
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
      if (m_bc4 != 4'hF)         m_bc4 = m_bc4 + 4'd1;
      if (bs) begin
        if (m_tc != 32'hFFFF_FFFF) m_tc = m_tc + 32'd1;
        if (m_tc4 != 4'hF)         m_tc4 = m_tc4 + 4'd1;
      end
    end
    m_flush = e_fl;
    e.pc = e_pc; e.fl = e_fl; e.mis = e_mis;
    e.bc = m_bc; e.tc = m_tc; e.bc4 = m_bc4; e.tc4 = m_tc4;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pc",        pc_a,    e.pc);
    chk("flush_ifid", {63'd0, fifd_a},  {63'd0, e.fl});
    chk("flush_idex", {63'd0, fidex_a}, {63'd0, e.fl});
    chk("misalign",  {63'd0, mis_a},   {63'd0, e.mis});
    chk("branch_cnt", {32'd0, bc_a},   {32'd0, e.bc});
    chk("taken_cnt",  {32'd0, tc_a},   {32'd0, e.tc});
    chk("pc_w4",     pc_b,    e.pc);
    chk("flush_ifid_w4", {63'd0, fifd_b},  {63'd0, e.fl});
    chk("flush_idex_w4", {63'd0, fidex_b}, {63'd0, e.fl});
    chk("misalign_w4",   {63'd0, mis_b},   {63'd0, e.mis});
    chk("branch_cnt_w4", {60'd0, bc_b}, {60'd0, e.bc4});
    chk("taken_cnt_w4",  {60'd0, tc_b}, {60'd0, e.tc4});
  endtask

  initial begin
    logic [63:0] t;
    m_bc = '0; m_tc = '0; m_bc4 = '0; m_tc4 = '0; m_flush = 1'b0;
    reset = 1'b1; Stall = 1'b0; BranchValid = 1'b0; BranchSel = 1'b0; BranchTarget = '0;

    //         st    bv    bs    target                  expected pc             fl    mis
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h4,                  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h8,                  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'hC,                  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h10,                 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 64'h200,               64'h200,                1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h204,                1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 64'h300,               64'h300,                1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 64'h500,               64'h304,                1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 64'h3C,                64'h3C,                 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h40,                 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 64'h900,               64'h40,                 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 64'h900,               64'h40,                 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 64'h900,               64'h40,                 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h44,                 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 64'h103,               64'h100,                1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h104,                1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 64'h700,               64'h108,                1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 64'h700,               64'h10C,                1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h0,                  1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b1, 64'h80,                64'h80,                 1'b1, 1'b0};

    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      step(1'b0, vecs[i].st, vecs[i].bv, vecs[i].bs, vecs[i].tgt,
           vecs[i].pc, vecs[i].fl, vecs[i].mis);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h84, 1'b0, 1'b0);

    // Enough taken branches to pin the narrow counters at all-ones and stay there.
    for (int i = 0; i < 18; i++) begin
      t = 64'h1000 + 64'(i) * 64'h10;
      step(1'b0, 1'b0, 1'b1, 1'b1, t, t, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, t + 64'h40, t + 64'h4, 1'b0, 1'b0);
    end

    // Reset landing in the flush cycle.
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h2000, 64'h2000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h3000, 64'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h4, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h600, 64'h600, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h604, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
Consumer end of the branch-unit decision interface. Owns the fetch program counter and implements static predict-not-taken. When the EX stage resolves a taken branch (BranchSel=1), it redirects the PC to BranchTarget and flushes the two younger instructions in IF/ID and ID/EX. It also keeps saturating branch/taken statistics counters for performance debug.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
CNT_W, 32, width of each statistics counter
PC_INCR, 4, sequential fetch increment in bytes

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Stall  input  1  hazard-unit hold request for the fetch PC
BranchValid  input  1  EX stage currently holds a conditional branch
BranchSel  input  1  branch-taken decision from the branch unit, qualified by BranchValid
BranchTarget  input  64  EX-stage computed branch target address
PC_Out  output  64  current fetch PC, registered
FlushIFID  output  1  kill the IF/ID register contents this cycle, registered
FlushIDEX  output  1  kill the ID/EX register contents this cycle, registered
MisalignErr  output  1  one-cycle pulse: taken target had bits[1:0] != 0
BranchCount  output  CNT_W  number of branches resolved
TakenCount  output  CNT_W  number of branches taken

Behaviour:
- Reset (synchronous, active-high) sets PC_Out=RESET_PC, sets FlushIFID, FlushIDEX, MisalignErr and both counters to 0, and sets state to RUN. Reset wins over every other input in every state, including mid-FLUSH.
- The FSM has two states, RUN and FLUSH.
- RUN, taken branch (BranchValid & BranchSel) in cycle N:
  - Cycle N+1: PC_Out = {BranchTarget[63:2],2'b00}, FlushIFID=1, FlushIDEX=1, state=FLUSH.
  - The redirect takes priority over Stall.
- RUN, no taken branch, Stall=1: PC_Out holds and the flush outputs are 0.
- RUN, no taken branch, Stall=0: PC_Out <= PC_Out+PC_INCR, computed modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- FLUSH lasts exactly one cycle, then returns to RUN.
  - In FLUSH, BranchValid, BranchSel and Stall are ignored, because they come from killed instructions.
  - PC_Out <= PC_Out+PC_INCR unconditionally.
  - FlushIFID and FlushIDEX return to 0 on the next edge.
- Flush outputs are 1 only in the single cycle after a taken branch resolves. Back-to-back taken branches therefore cannot be accepted: the second one is ignored because it sits in the flushed window.
- MisalignErr is a registered pulse in cycle N+1 when a taken branch has BranchTarget[1:0]!=0. The redirect still happens to the aligned address.
- Not-taken branch (BranchValid & !BranchSel): no redirect and no flush. PC follows the Stall rule.
- BranchSel with BranchValid=0 is ignored.
- Counters:
  - In RUN, BranchValid increments BranchCount. BranchValid & BranchSel also increments TakenCount.
  - Counters do not count in FLUSH. Counting is independent of Stall: a held branch counts once per cycle it is presented, so the hazard unit must deassert BranchValid while EX is stalled.
  - Counters saturate at all-ones and do not wrap.
- Latency: a decision presented in cycle N produces the redirected PC_Out in cycle N+1. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package:
  - State enum: RUN=1'b0, FLUSH=1'b1.
  - Constants PC_INCR and the default RESET_PC.
  - Alignment mask constant 64'hFFFF_FFFF_FFFF_FFFC.
- Sub-module: branch_stat_counter, a CNT_W-parameterised saturating counter with synchronous reset and inc enable. It is instantiated twice, once for BranchCount and once for TakenCount.

Test Plan:
- Reset behaviour: reset=1 for 2 cycles with RESET_PC=0, then release with Stall=0 and no branches -> PC_Out=0,4,8,12 on consecutive cycles, flushes stay 0.
- Taken branch: BranchValid=1, BranchSel=1, BranchTarget=64'h200 when PC_Out=0x10 -> next cycle PC_Out=0x200 with FlushIFID=FlushIDEX=1, then PC_Out=0x204 with flushes 0; BranchCount=1, TakenCount=1.
- Taken branch during stall and branch in the flush window:
  - Taken branch with Stall=1 in the same cycle -> redirect still occurs.
  - BranchValid=1, BranchSel=1 presented during FLUSH -> ignored, PC_Out=target+4, counters unchanged.
- Not-taken branch and stall hold: BranchValid=1, BranchSel=0 with Stall=1 for 3 cycles at PC_Out=0x40 -> PC_Out holds 0x40, no flush, BranchCount increments by 3, TakenCount unchanged.
- Misaligned target and wrap-around:
  - Taken branch with BranchTarget=64'h103 -> PC_Out=0x100, MisalignErr=1 for exactly one cycle.
  - PC_Out=0xFFFF_FFFF_FFFF_FFFC with Stall=0 -> next PC_Out=0.
- Saturation and reset mid-flush:
  - Force counters to all-ones (CNT_W=4 build) and present 3 taken branches -> both counters remain 4'hF.
  - Assert reset in the FLUSH cycle -> next cycle PC_Out=RESET_PC, flushes 0, state RUN.
